// File: rtl/arb_grant_responder_if.sv
// Signal bundle between arb_grant_responder, the round-robin arbiter and the shared resource.
// master = responder view, slave = arbiter/resource view.
interface arb_grant_responder_if;
    logic [7:0] req_set;
    logic [7:0] port_req;
    logic       gnt_valid;
    logic [2:0] gnt_port;
    logic       gnt_ack;
    logic [2:0] ack_port;
    logic       xfer_valid;
    logic       xfer_ready;
    logic [2:0] xfer_port;
    logic [7:0] xfer_beat;
    logic       xfer_last;
    logic       busy;
    logic       err;

    modport master (
        input  req_set,
        input  gnt_valid,
        input  gnt_port,
        input  xfer_ready,
        output port_req,
        output gnt_ack,
        output ack_port,
        output xfer_valid,
        output xfer_port,
        output xfer_beat,
        output xfer_last,
        output busy,
        output err
    );

    modport slave (
        output req_set,
        output gnt_valid,
        output gnt_port,
        output xfer_ready,
        input  port_req,
        input  gnt_ack,
        input  ack_port,
        input  xfer_valid,
        input  xfer_port,
        input  xfer_beat,
        input  xfer_last,
        input  busy,
        input  err
    );
endinterface

// File: rtl/arb_grant_responder.sv
// Requester-side partner of the 8-port round-robin arbiter: sticky requests, burst transfer, grant ack.
// Optional stall timeout abort enabled by defining ARB_RESP_TIMEOUT_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a grant that matches a pending port_req bit
// XFER  | issuing BURST_LEN beats for xfer_port
// ACK   | gnt_ack pulse with ack_port = xfer_port
// HOLD  | HOLDOFF_CYC idle cycles while the arbiter pipeline drains
module arb_grant_responder #(
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned HOLDOFF_CYC = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    arb_grant_responder_if.master bus
);

    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("arb_grant_responder: BURST_LEN must be 1..255");
    end
    if (HOLDOFF_CYC > 15) begin : g_bad_holdoff
        $error("arb_grant_responder: HOLDOFF_CYC must be 0..15");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("arb_grant_responder: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [3:0] HOLD_LOAD = 4'((HOLDOFF_CYC > 0) ? (HOLDOFF_CYC - 1) : 0);

    state_t     state;
    logic [7:0] port_req_q;
    logic [7:0] beat;
    logic [3:0] hold_cnt;
    logic [2:0] xfer_port_q;
    logic [2:0] ack_port_q;
    logic       xfer_valid_q;
    logic       xfer_last_q;
    logic       gnt_ack_q;
    logic       busy_q;

    logic       accept;
    logic       beat_done;
    logic [7:0] clr;
    logic [7:0] beat_nxt;

`ifdef ARB_RESP_TIMEOUT_EN
    localparam int unsigned      STALL_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(TIMEOUT_CYC - 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               err_q;
`endif

    always_comb begin
        accept = 1'b0;
        clr    = '0;
        if (state == IDLE && bus.gnt_valid && port_req_q[bus.gnt_port]) begin
            accept             = 1'b1;
            clr[bus.gnt_port]  = 1'b1;
        end
    end

    assign beat_done = xfer_valid_q && bus.xfer_ready;
    assign beat_nxt  = beat + 8'd1;

    // A fresh req_set beats the clear of the same bit, so it becomes a new request.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_req_q <= '0;
        end else begin
            port_req_q <= (port_req_q & ~clr) | bus.req_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            beat         <= '0;
            hold_cnt     <= '0;
            xfer_port_q  <= '0;
            ack_port_q   <= '0;
            xfer_valid_q <= 1'b0;
            xfer_last_q  <= 1'b0;
            gnt_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ARB_RESP_TIMEOUT_EN
            stall_cnt    <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            gnt_ack_q <= 1'b0;
`ifdef ARB_RESP_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= XFER;
                        busy_q       <= 1'b1;
                        xfer_port_q  <= bus.gnt_port;
                        beat         <= '0;
                        xfer_valid_q <= 1'b1;
                        xfer_last_q  <= (LAST_BEAT == 8'd0);
`ifdef ARB_RESP_TIMEOUT_EN
                        stall_cnt    <= STALL_LOAD;
`endif
                    end
                end

                XFER: begin
`ifdef ARB_RESP_TIMEOUT_EN
                    // xfer_valid is only low here on the cycle after a timeout abort.
                    if (!xfer_valid_q) begin
                        state      <= ACK;
                        beat       <= '0;
                        gnt_ack_q  <= 1'b1;
                        ack_port_q <= xfer_port_q;
                    end else
`endif
                    if (beat_done) begin
                        if (xfer_last_q) begin
                            state        <= ACK;
                            beat         <= '0;
                            xfer_valid_q <= 1'b0;
                            xfer_last_q  <= 1'b0;
                            gnt_ack_q    <= 1'b1;
                            ack_port_q   <= xfer_port_q;
                        end else begin
                            beat        <= beat_nxt;
                            xfer_last_q <= (beat_nxt == LAST_BEAT);
`ifdef ARB_RESP_TIMEOUT_EN
                            stall_cnt   <= STALL_LOAD;
`endif
                        end
                    end
`ifdef ARB_RESP_TIMEOUT_EN
                    else if (stall_cnt == '0) begin
                        err_q        <= 1'b1;
                        xfer_valid_q <= 1'b0;
                        xfer_last_q  <= 1'b0;
                    end else begin
                        stall_cnt <= stall_cnt - 1'b1;
                    end
`endif
                end

                ACK: begin
                    if (HOLDOFF_CYC == 0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                end

                HOLD: begin
                    if (hold_cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                default: begin
                    state        <= IDLE;
                    busy_q       <= 1'b0;
                    xfer_valid_q <= 1'b0;
                    xfer_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.port_req   = port_req_q;
    assign bus.gnt_ack    = gnt_ack_q;
    assign bus.ack_port   = ack_port_q;
    assign bus.xfer_valid = xfer_valid_q;
    assign bus.xfer_port  = xfer_port_q;
    assign bus.xfer_beat  = beat;
    assign bus.xfer_last  = xfer_last_q;
    assign bus.busy       = busy_q;
`ifdef ARB_RESP_TIMEOUT_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_arb_grant_responder.sv
// Directed self-checking bench for arb_grant_responder (BURST_LEN=4, HOLDOFF_CYC=2, TIMEOUT_CYC=16).
module tb_arb_grant_responder;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    arb_grant_responder_if bus ();

    arb_grant_responder #(
        .BURST_LEN   (4),
        .HOLDOFF_CYC (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.req_set    = '0;
        bus.gnt_valid  = 1'b0;
        bus.gnt_port   = '0;
        bus.xfer_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({bus.port_req, bus.gnt_ack, bus.ack_port, bus.xfer_valid, bus.xfer_port,
             bus.xfer_beat, bus.xfer_last, bus.busy, bus.err} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got port_req=%h gnt_ack=%b xfer_valid=%b busy=%b err=%b exp all 0",
                     bus.port_req, bus.gnt_ack, bus.xfer_valid, bus.busy, bus.err);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.xfer_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b xfer_valid=%b exp 0 0", bus.busy, bus.xfer_valid);
        end
    endtask

    task automatic test_single_burst();
        bus.req_set = 8'h04;
        tick();
        bus.req_set = 8'h00;
        checks++;
        if (bus.port_req !== 8'h04) begin
            errors++;
            $display("FAIL single_port_req_set got=%h exp=04", bus.port_req);
        end
        bus.gnt_valid = 1'b1;
        bus.gnt_port  = 3'd2;
        tick();
        bus.gnt_valid = 1'b0;
        checks++;
        if (bus.port_req !== 8'h00 || bus.xfer_port !== 3'd2 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept got port_req=%h xfer_port=%0d busy=%b exp 00 2 1",
                     bus.port_req, bus.xfer_port, bus.busy);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (bus.xfer_valid !== 1'b1 || bus.xfer_beat !== 8'(b) ||
                bus.xfer_last !== (b == 3) || bus.gnt_ack !== 1'b0) begin
                errors++;
                $display("FAIL single_beat%0d got valid=%b beat=%0d last=%b ack=%b exp 1 %0d %b 0",
                         b, bus.xfer_valid, bus.xfer_beat, bus.xfer_last, bus.gnt_ack, b, (b == 3));
            end
            tick();
        end
        checks++;
        if (bus.gnt_ack !== 1'b1 || bus.ack_port !== 3'd2 || bus.xfer_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got gnt_ack=%b ack_port=%0d xfer_valid=%b exp 1 2 0",
                     bus.gnt_ack, bus.ack_port, bus.xfer_valid);
        end
        tick();
        checks++;
        if (bus.gnt_ack !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack_pulse got gnt_ack=%b busy=%b exp 0 1", bus.gnt_ack, bus.busy);
        end
        repeat (2) tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_back_idle got busy=%b exp 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        bus.req_set = 8'h81;
        tick();
        bus.req_set   = 8'h00;
        bus.gnt_valid = 1'b1;
        bus.gnt_port  = 3'd7;
        tick();
        bus.gnt_valid = 1'b0;
        checks++;
        if (bus.xfer_port !== 3'd7 || bus.port_req !== 8'h01) begin
            errors++;
            $display("FAIL b2b_accept7 got xfer_port=%0d port_req=%h exp 7 01", bus.xfer_port, bus.port_req);
        end
        repeat (4) tick();
        checks++;
        if (bus.gnt_ack !== 1'b1 || bus.ack_port !== 3'd7) begin
            errors++;
            $display("FAIL b2b_ack7 got gnt_ack=%b ack_port=%0d exp 1 7", bus.gnt_ack, bus.ack_port);
        end
        // Arbiter grants port 0 right away; it must be held off through both HOLD cycles.
        bus.gnt_valid = 1'b1;
        bus.gnt_port  = 3'd0;
        for (int h = 0; h < 3; h++) begin
            tick();
            checks++;
            if (bus.xfer_valid !== 1'b0 || bus.port_req !== 8'h01 || bus.busy !== (h < 2)) begin
                errors++;
                $display("FAIL b2b_holdoff%0d got xfer_valid=%b port_req=%h busy=%b exp 0 01 %b",
                         h, bus.xfer_valid, bus.port_req, bus.busy, (h < 2));
            end
        end
        checks++;
        if (bus.ack_port !== 3'd7) begin
            errors++;
            $display("FAIL b2b_ack_port_hold got=%0d exp=7", bus.ack_port);
        end
        tick();
        bus.gnt_valid = 1'b0;
        checks++;
        if (bus.xfer_valid !== 1'b1 || bus.xfer_port !== 3'd0 || bus.port_req !== 8'h00) begin
            errors++;
            $display("FAIL b2b_accept0 got xfer_valid=%b xfer_port=%0d port_req=%h exp 1 0 00",
                     bus.xfer_valid, bus.xfer_port, bus.port_req);
        end
        repeat (4) tick();
        checks++;
        if (bus.gnt_ack !== 1'b1 || bus.ack_port !== 3'd0) begin
            errors++;
            $display("FAIL b2b_ack0 got gnt_ack=%b ack_port=%0d exp 1 0", bus.gnt_ack, bus.ack_port);
        end
        repeat (3) tick();
    endtask

    task automatic test_stale_grant();
        bus.gnt_valid = 1'b1;
        bus.gnt_port  = 3'd5;
        repeat (3) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.xfer_valid !== 1'b0 || bus.gnt_ack !== 1'b0) begin
                errors++;
                $display("FAIL stale_grant got busy=%b xfer_valid=%b gnt_ack=%b exp 0 0 0",
                         bus.busy, bus.xfer_valid, bus.gnt_ack);
            end
        end
        bus.gnt_valid = 1'b0;
    endtask

    task automatic test_ready_toggle();
        logic       rdy_pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] beat_exp [6] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
        bus.req_set = 8'h02;
        tick();
        bus.req_set   = 8'h00;
        bus.gnt_valid = 1'b1;
        bus.gnt_port  = 3'd1;
        tick();
        bus.gnt_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.xfer_ready = rdy_pat[i];
            checks++;
            if (bus.xfer_valid !== 1'b1 || bus.xfer_beat !== beat_exp[i] || bus.gnt_ack !== 1'b0) begin
                errors++;
                $display("FAIL ready_toggle_cyc%0d got valid=%b beat=%0d ack=%b exp 1 %0d 0",
                         i, bus.xfer_valid, bus.xfer_beat, bus.gnt_ack, beat_exp[i]);
            end
            tick();
        end
        bus.xfer_ready = 1'b1;
        checks++;
        if (bus.gnt_ack !== 1'b1 || bus.ack_port !== 3'd1) begin
            errors++;
            $display("FAIL ready_toggle_ack got gnt_ack=%b ack_port=%0d exp 1 1", bus.gnt_ack, bus.ack_port);
        end
        repeat (3) tick();
    endtask

    task automatic test_set_during_accept();
        bus.req_set = 8'h08;
        tick();
        bus.gnt_valid = 1'b1;
        bus.gnt_port  = 3'd3;
        tick();
        bus.gnt_valid = 1'b0;
        bus.req_set   = 8'h00;
        checks++;
        if (bus.port_req !== 8'h08 || bus.xfer_port !== 3'd3 || bus.xfer_valid !== 1'b1) begin
            errors++;
            $display("FAIL set_wins got port_req=%h xfer_port=%0d xfer_valid=%b exp 08 3 1",
                     bus.port_req, bus.xfer_port, bus.xfer_valid);
        end
        repeat (4) tick();
        checks++;
        if (bus.gnt_ack !== 1'b1 || bus.ack_port !== 3'd3) begin
            errors++;
            $display("FAIL set_wins_ack1 got gnt_ack=%b ack_port=%0d exp 1 3", bus.gnt_ack, bus.ack_port);
        end
        repeat (3) tick();
        bus.gnt_valid = 1'b1;
        tick();
        bus.gnt_valid = 1'b0;
        checks++;
        if (bus.port_req !== 8'h00 || bus.xfer_valid !== 1'b1 || bus.xfer_port !== 3'd3) begin
            errors++;
            $display("FAIL set_wins_second got port_req=%h xfer_valid=%b xfer_port=%0d exp 00 1 3",
                     bus.port_req, bus.xfer_valid, bus.xfer_port);
        end
        repeat (4) tick();
        checks++;
        if (bus.gnt_ack !== 1'b1 || bus.ack_port !== 3'd3) begin
            errors++;
            $display("FAIL set_wins_ack2 got gnt_ack=%b ack_port=%0d exp 1 3", bus.gnt_ack, bus.ack_port);
        end
        repeat (3) tick();
    endtask

    task automatic test_stall();
        bus.req_set = 8'h10;
        tick();
        bus.req_set    = 8'h00;
        bus.gnt_valid  = 1'b1;
        bus.gnt_port   = 3'd4;
        bus.xfer_ready = 1'b0;
        tick();
        bus.gnt_valid = 1'b0;
`ifdef ARB_RESP_TIMEOUT_EN
        repeat (15) tick();
        checks++;
        if (bus.err !== 1'b0 || bus.xfer_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early got err=%b xfer_valid=%b exp 0 1", bus.err, bus.xfer_valid);
        end
        tick();
        checks++;
        if (bus.err !== 1'b1 || bus.xfer_valid !== 1'b0 || bus.gnt_ack !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err got err=%b xfer_valid=%b gnt_ack=%b exp 1 0 0",
                     bus.err, bus.xfer_valid, bus.gnt_ack);
        end
        tick();
        checks++;
        if (bus.err !== 1'b0 || bus.gnt_ack !== 1'b1 || bus.ack_port !== 3'd4) begin
            errors++;
            $display("FAIL timeout_ack got err=%b gnt_ack=%b ack_port=%0d exp 0 1 4",
                     bus.err, bus.gnt_ack, bus.ack_port);
        end
        bus.xfer_ready = 1'b1;
        repeat (3) tick();
`else
        repeat (20) tick();
        checks++;
        if (bus.xfer_valid !== 1'b1 || bus.err !== 1'b0 || bus.xfer_beat !== 8'd0 || bus.gnt_ack !== 1'b0) begin
            errors++;
            $display("FAIL stall_waits got xfer_valid=%b err=%b beat=%0d gnt_ack=%b exp 1 0 0 0",
                     bus.xfer_valid, bus.err, bus.xfer_beat, bus.gnt_ack);
        end
        bus.xfer_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (bus.gnt_ack !== 1'b1 || bus.ack_port !== 3'd4) begin
            errors++;
            $display("FAIL stall_ack got gnt_ack=%b ack_port=%0d exp 1 4", bus.gnt_ack, bus.ack_port);
        end
        repeat (3) tick();
`endif
    endtask

    task automatic test_reset_mid_xfer();
        bus.req_set = 8'h20;
        tick();
        bus.req_set    = 8'h02;
        bus.gnt_valid  = 1'b1;
        bus.gnt_port   = 3'd5;
        bus.xfer_ready = 1'b0;
        tick();
        bus.gnt_valid = 1'b0;
        bus.req_set   = 8'h00;
        tick();
        checks++;
        if (bus.xfer_valid !== 1'b1 || bus.port_req !== 8'h02) begin
            errors++;
            $display("FAIL rst_mid_setup got xfer_valid=%b port_req=%h exp 1 02", bus.xfer_valid, bus.port_req);
        end
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        bus.xfer_ready = 1'b1;
        checks++;
        if ({bus.port_req, bus.gnt_ack, bus.ack_port, bus.xfer_valid, bus.xfer_port,
             bus.xfer_beat, bus.xfer_last, bus.busy, bus.err} !== 27'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got port_req=%h gnt_ack=%b ack_port=%0d xfer_valid=%b xfer_port=%0d busy=%b exp all 0",
                     bus.port_req, bus.gnt_ack, bus.ack_port, bus.xfer_valid, bus.xfer_port, bus.busy);
        end
        repeat (4) begin
            tick();
            checks++;
            if (bus.gnt_ack !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_no_ack got gnt_ack=%b busy=%b exp 0 0", bus.gnt_ack, bus.busy);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_stale_grant();
        test_ready_toggle();
        test_set_during_accept();
        test_stall();
        test_reset_mid_xfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
